// File: rtl/priv_trap_sequencer_if.sv
// Handshake and CSR-update bundle between the pipeline/CSR file (master) and
// the machine-mode trap sequencer (slave).
interface priv_trap_sequencer_if;
    logic [15:0] exc_vec;
    logic [11:0] mip_in;
    logic [11:0] mie_in;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] epc_in;
    logic [31:0] tval_in;
    logic        mret_req;
    logic        pipe_clear;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic [31:0] mcause_next;
    logic [31:0] mepc_next;
    logic [31:0] mtval_next;
    logic        mstatus_mie_next;
    logic        mstatus_mpie_next;
    logic        mcause_rup;
    logic        mepc_rup;
    logic        mtval_rup;
    logic        mstatus_rup;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic        trap_busy;

    modport master (
        output exc_vec, mip_in, mie_in, mstatus_mie, mstatus_mpie, epc_in, tval_in,
               mret_req, pipe_clear, mtvec_in, mepc_in,
        input  mcause_next, mepc_next, mtval_next, mstatus_mie_next, mstatus_mpie_next,
               mcause_rup, mepc_rup, mtval_rup, mstatus_rup, insert_pc, priv_pc, trap_busy
    );

    modport slave (
        input  exc_vec, mip_in, mie_in, mstatus_mie, mstatus_mpie, epc_in, tval_in,
               mret_req, pipe_clear, mtvec_in, mepc_in,
        output mcause_next, mepc_next, mtval_next, mstatus_mie_next, mstatus_mpie_next,
               mcause_rup, mepc_rup, mtval_rup, mstatus_rup, insert_pc, priv_pc, trap_busy
    );
endinterface

// File: rtl/priv_trap_sequencer.sv
// Machine-mode trap/mret sequencer: picks the winning event, waits for the pipeline
// to drain, strobes the CSR updates for one cycle, then redirects fetch.
module priv_trap_sequencer #(
    parameter int XLEN        = 32,
    parameter bit VECTORED_EN = 1'b1
) (
    input logic                   CLK,
    input logic                   RST,
    priv_trap_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_CLEAR  = 3'd1,
        COMMIT      = 3'd2,
        MRET_COMMIT = 3'd3,
        REDIRECT    = 3'd4
    } state_t;

    localparam logic [15:0] EXC_MASK = 16'hBBFF;
    localparam logic [11:0] IRQ_MASK = 12'hBBB;
    localparam logic [3:0]  EXC_ORDER [14] = '{4'd12, 4'd1, 4'd2, 4'd0, 4'd11, 4'd9, 4'd8,
                                               4'd3, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};
    localparam logic [3:0]  IRQ_ORDER [9]  = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5, 4'd8,
                                               4'd0, 4'd4};

    // Walk from lowest to highest priority so the strongest request overwrites.
    function automatic logic [4:0] exc_code(input logic [15:0] req);
        logic [4:0] code;
        code = 5'd0;
        for (int i = 13; i >= 0; i--) begin
            if (req[EXC_ORDER[i]]) begin
                code = {1'b0, EXC_ORDER[i]};
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    function automatic logic [4:0] irq_code(input logic [11:0] req);
        logic [4:0] code;
        code = 5'd0;
        for (int i = 8; i >= 0; i--) begin
            if (req[IRQ_ORDER[i]]) begin
                code = {1'b0, IRQ_ORDER[i]};
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    state_t            state_q, state_d;
    logic [4:0]        code_q, code_d;
    logic              is_int_q, is_int_d;
    logic              mret_q, mret_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [31:0]       tval_q, tval_d;
    logic [31:0]       mcause_next_q, mcause_next_d;
    logic [XLEN-1:0]   mepc_next_q, mepc_next_d;
    logic [31:0]       mtval_next_q, mtval_next_d;
    logic              mie_next_q, mie_next_d;
    logic              mpie_next_q, mpie_next_d;
    logic              csr_rup_q, csr_rup_d;
    logic              mstatus_rup_q, mstatus_rup_d;
    logic              insert_pc_q, insert_pc_d;
    logic [31:0]       priv_pc_q, priv_pc_d;
    logic              trap_busy_q, trap_busy_d;

    logic [15:0]       exc_s;
    logic [11:0]       irq_s;
    logic [31:0]       trap_base_s;
    logic [31:0]       trap_target_s;

    // Next-state, latch and registered-output computation.
    always_comb begin
        exc_s         = bus.exc_vec & EXC_MASK;
        irq_s         = bus.mip_in & bus.mie_in & {12{bus.mstatus_mie}} & IRQ_MASK;
        trap_base_s   = {bus.mtvec_in[31:2], 2'b00};
        if (VECTORED_EN && (bus.mtvec_in[1:0] == 2'b01) && is_int_q) begin
            trap_target_s = trap_base_s + {25'd0, code_q, 2'b00};
        end else begin
            trap_target_s = trap_base_s;
        end

        state_d       = state_q;
        code_d        = code_q;
        is_int_d      = is_int_q;
        mret_d        = mret_q;
        epc_d         = epc_q;
        tval_d        = tval_q;

        case (state_q)
            IDLE: begin
                if (|exc_s) begin
                    code_d   = exc_code(exc_s);
                    is_int_d = 1'b0;
                    mret_d   = 1'b0;
                    epc_d    = bus.epc_in & 32'hFFFF_FFFC;
                    tval_d   = bus.tval_in;
                    state_d  = bus.pipe_clear ? COMMIT : WAIT_CLEAR;
                end else if (|irq_s) begin
                    code_d   = irq_code(irq_s);
                    is_int_d = 1'b1;
                    mret_d   = 1'b0;
                    epc_d    = bus.epc_in & 32'hFFFF_FFFC;
                    tval_d   = 32'd0;
                    state_d  = bus.pipe_clear ? COMMIT : WAIT_CLEAR;
                end else if (bus.mret_req) begin
                    mret_d   = 1'b1;
                    state_d  = bus.pipe_clear ? MRET_COMMIT : WAIT_CLEAR;
                end else begin
                    state_d  = IDLE;
                end
            end
            WAIT_CLEAR: begin
                if (bus.pipe_clear) begin
                    state_d = mret_q ? MRET_COMMIT : COMMIT;
                end else begin
                    state_d = WAIT_CLEAR;
                end
            end
            COMMIT:      state_d = REDIRECT;
            MRET_COMMIT: state_d = REDIRECT;
            REDIRECT:    state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        mcause_next_d = mcause_next_q;
        mepc_next_d   = mepc_next_q;
        mtval_next_d  = mtval_next_q;
        mie_next_d    = mie_next_q;
        mpie_next_d   = mpie_next_q;
        priv_pc_d     = priv_pc_q;
        csr_rup_d     = 1'b0;
        mstatus_rup_d = 1'b0;
        insert_pc_d   = 1'b0;
        trap_busy_d   = (state_d != IDLE);

        case (state_d)
            COMMIT: begin
                csr_rup_d     = 1'b1;
                mstatus_rup_d = 1'b1;
                mcause_next_d = {is_int_d, 26'd0, code_d};
                mepc_next_d   = epc_d;
                mtval_next_d  = tval_d;
                mpie_next_d   = bus.mstatus_mie;
                mie_next_d    = 1'b0;
            end
            MRET_COMMIT: begin
                mstatus_rup_d = 1'b1;
                mie_next_d    = bus.mstatus_mpie;
                mpie_next_d   = 1'b1;
            end
            REDIRECT: begin
                insert_pc_d = 1'b1;
                if (mret_q) begin
                    priv_pc_d = bus.mepc_in & 32'hFFFF_FFFC;
                end else begin
                    priv_pc_d = trap_target_s;
                end
            end
            default: begin
                insert_pc_d = 1'b0;
            end
        endcase
    end

    // Sequencer state, event latches and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            code_q        <= 5'd0;
            is_int_q      <= 1'b0;
            mret_q        <= 1'b0;
            epc_q         <= '0;
            tval_q        <= 32'd0;
            mcause_next_q <= 32'd0;
            mepc_next_q   <= '0;
            mtval_next_q  <= 32'd0;
            mie_next_q    <= 1'b0;
            mpie_next_q   <= 1'b0;
            csr_rup_q     <= 1'b0;
            mstatus_rup_q <= 1'b0;
            insert_pc_q   <= 1'b0;
            priv_pc_q     <= 32'd0;
            trap_busy_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            is_int_q      <= is_int_d;
            mret_q        <= mret_d;
            epc_q         <= epc_d;
            tval_q        <= tval_d;
            mcause_next_q <= mcause_next_d;
            mepc_next_q   <= mepc_next_d;
            mtval_next_q  <= mtval_next_d;
            mie_next_q    <= mie_next_d;
            mpie_next_q   <= mpie_next_d;
            csr_rup_q     <= csr_rup_d;
            mstatus_rup_q <= mstatus_rup_d;
            insert_pc_q   <= insert_pc_d;
            priv_pc_q     <= priv_pc_d;
            trap_busy_q   <= trap_busy_d;
        end
    end

    assign bus.mcause_next       = mcause_next_q;
    assign bus.mepc_next         = mepc_next_q;
    assign bus.mtval_next        = mtval_next_q;
    assign bus.mstatus_mie_next  = mie_next_q;
    assign bus.mstatus_mpie_next = mpie_next_q;
    assign bus.mcause_rup        = csr_rup_q;
    assign bus.mepc_rup          = csr_rup_q;
    assign bus.mtval_rup         = csr_rup_q;
    assign bus.mstatus_rup       = mstatus_rup_q;
    assign bus.insert_pc         = insert_pc_q;
    assign bus.priv_pc           = priv_pc_q;
    assign bus.trap_busy         = trap_busy_q;
endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Self-checking bench: vector table plus hand sequences, with commit and redirect
// expectations queued at stimulus time and checked when the DUT strobes.
module tb_priv_trap_sequencer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] exc_vec = 16'd0;
    logic [11:0] mip_in = 12'd0;
    logic [11:0] mie_in = 12'd0;
    logic        st_mie = 1'b0;
    logic        st_mpie = 1'b0;
    logic [31:0] epc_in = 32'd0;
    logic [31:0] tval_in = 32'd0;
    logic        mret_req = 1'b0;
    logic        pipe_clear = 1'b0;
    logic [31:0] mtvec_in = 32'd0;
    logic [31:0] mepc_in = 32'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    priv_trap_sequencer_if u_if0 ();
    priv_trap_sequencer_if u_if1 ();

    assign u_if0.exc_vec = exc_vec;       assign u_if1.exc_vec = exc_vec;
    assign u_if0.mip_in = mip_in;         assign u_if1.mip_in = mip_in;
    assign u_if0.mie_in = mie_in;         assign u_if1.mie_in = mie_in;
    assign u_if0.mstatus_mie = st_mie;    assign u_if1.mstatus_mie = st_mie;
    assign u_if0.mstatus_mpie = st_mpie;  assign u_if1.mstatus_mpie = st_mpie;
    assign u_if0.epc_in = epc_in;         assign u_if1.epc_in = epc_in;
    assign u_if0.tval_in = tval_in;       assign u_if1.tval_in = tval_in;
    assign u_if0.mret_req = mret_req;     assign u_if1.mret_req = mret_req;
    assign u_if0.pipe_clear = pipe_clear; assign u_if1.pipe_clear = pipe_clear;
    assign u_if0.mtvec_in = mtvec_in;     assign u_if1.mtvec_in = mtvec_in;
    assign u_if0.mepc_in = mepc_in;       assign u_if1.mepc_in = mepc_in;

    priv_trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) u_dut_vec (.CLK(CLK), .RST(RST), .bus(u_if0));
    priv_trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b0)) u_dut_dir (.CLK(CLK), .RST(RST), .bus(u_if1));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] exc; logic [11:0] mip; logic [11:0] mie; logic smie; logic smpie;
        logic [31:0] epc; logic [31:0] tval; logic mret; logic [31:0] mtvec; logic [31:0] mepc;
        logic [1:0]  kind;   // 0 no event, 1 trap, 2 mret
        logic [31:0] e_cause; logic [31:0] e_mepc; logic [31:0] e_tval;
        logic e_mie; logic e_mpie; logic [31:0] e_pc; logic [31:0] e_pc_dir;
    } vec_t;

    typedef struct {
        logic mret; logic [31:0] cause; logic [31:0] mepc; logic [31:0] tval;
        logic mie; logic mpie; int cyc;
    } cexp_t;

    typedef struct { logic [31:0] pc; int cyc; } pexp_t;

    cexp_t cq[$];
    pexp_t pq0[$];
    pexp_t pq1[$];
    cexp_t mon_c;
    pexp_t mon_p;
    vec_t  tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_trap(input logic [31:0] cause, input logic [31:0] mepc, input logic [31:0] tval,
                             input logic mpie, input logic [31:0] pc, input logic [31:0] pc_dir, input int at);
        cq.push_back('{1'b0, cause, mepc, tval, 1'b0, mpie, at});
        pq0.push_back('{pc, at + 1});
        pq1.push_back('{pc_dir, at + 1});
    endtask

    task automatic clear_events();
        exc_vec = 16'd0; mip_in = 12'd0; mie_in = 12'd0; mret_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (u_if0.mcause_rup | u_if0.mepc_rup | u_if0.mtval_rup | u_if0.mstatus_rup) begin
                if (cq.size() == 0) begin
                    chk("unexpected_strobe", {28'd0, u_if0.mcause_rup, u_if0.mepc_rup,
                        u_if0.mtval_rup, u_if0.mstatus_rup}, 32'd0);
                end else begin
                    mon_c = cq.pop_front();
                    chk("strobes", {28'd0, u_if0.mcause_rup, u_if0.mepc_rup, u_if0.mtval_rup,
                        u_if0.mstatus_rup}, mon_c.mret ? 32'h1 : 32'hF);
                    chk("commit_cycle", 32'(cyc), 32'(mon_c.cyc));
                    if (!mon_c.mret) begin
                        chk("mcause_next", u_if0.mcause_next, mon_c.cause);
                        chk("mepc_next", u_if0.mepc_next, mon_c.mepc);
                        chk("mtval_next", u_if0.mtval_next, mon_c.tval);
                    end
                    chk("mstatus_mie_next", 32'(u_if0.mstatus_mie_next), 32'(mon_c.mie));
                    chk("mstatus_mpie_next", 32'(u_if0.mstatus_mpie_next), 32'(mon_c.mpie));
                end
            end
            if (u_if0.insert_pc) begin
                if (pq0.size() == 0) begin
                    chk("unexpected_insert_pc", 32'd1, 32'd0);
                end else begin
                    mon_p = pq0.pop_front();
                    chk("priv_pc_vec", u_if0.priv_pc, mon_p.pc);
                    chk("redirect_cycle", 32'(cyc), 32'(mon_p.cyc));
                end
            end
            if (u_if1.insert_pc) begin
                if (pq1.size() == 0) begin
                    chk("unexpected_insert_pc_dir", 32'd1, 32'd0);
                end else begin
                    mon_p = pq1.pop_front();
                    chk("priv_pc_dir", u_if1.priv_pc, mon_p.pc);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{16'h0004, 12'h000, 12'h000, 1'b1, 1'b0, 32'h100, 32'hDEAD, 1'b0, 32'h8000, 32'h0,
                    2'd1, 32'h2, 32'h100, 32'hDEAD, 1'b0, 1'b1, 32'h8000, 32'h8000};
        tbl[1]  = '{16'h0000, 12'h080, 12'h080, 1'b1, 1'b0, 32'h200, 32'h55, 1'b0, 32'h8001, 32'h0,
                    2'd1, 32'h80000007, 32'h200, 32'h0, 1'b0, 1'b1, 32'h801C, 32'h8000};
        tbl[2]  = '{16'h0808, 12'h800, 12'h800, 1'b1, 1'b1, 32'h300, 32'h77, 1'b1, 32'h8001, 32'h4000,
                    2'd1, 32'hB, 32'h300, 32'h77, 1'b0, 1'b1, 32'h8000, 32'h8000};
        tbl[3]  = '{16'hFFFF, 12'hFFF, 12'hFFF, 1'b0, 1'b1, 32'h403, 32'h1, 1'b0, 32'h9002, 32'h0,
                    2'd1, 32'hC, 32'h400, 32'h1, 1'b0, 1'b0, 32'h9000, 32'h9000};
        tbl[4]  = '{16'h00A0, 12'h000, 12'h000, 1'b1, 1'b0, 32'h604, 32'h604, 1'b0, 32'h8001, 32'h0,
                    2'd1, 32'h7, 32'h604, 32'h604, 1'b0, 1'b1, 32'h8000, 32'h8000};
        tbl[5]  = '{16'h0000, 12'hFFF, 12'h088, 1'b1, 1'b0, 32'h700, 32'h9, 1'b0, 32'h8001, 32'h0,
                    2'd1, 32'h80000003, 32'h700, 32'h0, 1'b0, 1'b1, 32'h800C, 32'h8000};
        tbl[6]  = '{16'h0000, 12'h080, 12'h080, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8001, 32'h0,
                    2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[7]  = '{16'h4400, 12'h444, 12'h444, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8001, 32'h0,
                    2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[8]  = '{16'h0000, 12'h644, 12'h644, 1'b1, 1'b0, 32'h800, 32'h3, 1'b0, 32'h8001, 32'h0,
                    2'd1, 32'h80000009, 32'h800, 32'h0, 1'b0, 1'b1, 32'h8024, 32'h8000};
        tbl[9]  = '{16'h0000, 12'h000, 12'h000, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h8000, 32'h1236,
                    2'd2, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1234, 32'h1234};
        tbl[10] = '{16'h0000, 12'h000, 12'h000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8000, 32'hFFFFFFFF,
                    2'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC};
        tbl[11] = '{16'h0000, 12'h800, 12'h800, 1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 32'hFFFFFFF1, 32'h0,
                    2'd1, 32'h8000000B, 32'h900, 32'h0, 1'b0, 1'b1, 32'h0000001C, 32'hFFFFFFF0};
        tbl[12] = '{16'h0000, 12'h002, 12'h002, 1'b1, 1'b0, 32'hA10, 32'h0, 1'b0, 32'h8003, 32'h0,
                    2'd1, 32'h80000001, 32'hA10, 32'h0, 1'b0, 1'b1, 32'h8000, 32'h8000};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 32'(|{u_if0.mcause_next, u_if0.mepc_next, u_if0.mtval_next,
            u_if0.mstatus_mie_next, u_if0.mstatus_mpie_next, u_if0.mcause_rup, u_if0.mstatus_rup,
            u_if0.insert_pc, u_if0.priv_pc, u_if0.trap_busy}), 32'd0);
        RST = 1'b0;
        tick();
        chk("idle_busy", 32'(u_if0.trap_busy), 32'd0);

        // Table-driven vectors, pipeline already drained
        for (int i = 0; i < 13; i++) begin
            exc_vec = tbl[i].exc; mip_in = tbl[i].mip; mie_in = tbl[i].mie;
            st_mie = tbl[i].smie; st_mpie = tbl[i].smpie; epc_in = tbl[i].epc;
            tval_in = tbl[i].tval; mret_req = tbl[i].mret; mtvec_in = tbl[i].mtvec;
            mepc_in = tbl[i].mepc; pipe_clear = 1'b1;
            if (tbl[i].kind == 2'd1) begin
                push_trap(tbl[i].e_cause, tbl[i].e_mepc, tbl[i].e_tval, tbl[i].e_mpie,
                          tbl[i].e_pc, tbl[i].e_pc_dir, cyc + 1);
            end else if (tbl[i].kind == 2'd2) begin
                cq.push_back('{1'b1, 32'd0, 32'd0, 32'd0, tbl[i].e_mie, tbl[i].e_mpie, cyc + 1});
                pq0.push_back('{tbl[i].e_pc, cyc + 2});
                pq1.push_back('{tbl[i].e_pc_dir, cyc + 2});
            end
            tick();
            clear_events();
            chk($sformatf("busy_v%0d", i), 32'(u_if0.trap_busy), (tbl[i].kind != 2'd0) ? 32'd1 : 32'd0);
            repeat (3) tick();
            chk($sformatf("idle_v%0d", i), 32'(u_if0.trap_busy), 32'd0);
            chk($sformatf("drained_v%0d", i), 32'(cq.size() + pq0.size() + pq1.size()), 32'd0);
        end

        // Drain wait: later requests must not disturb the latched trap
        st_mie = 1'b1; mtvec_in = 32'h8000;
        exc_vec = 16'h0004; epc_in = 32'h500; tval_in = 32'hBEEF; pipe_clear = 1'b0;
        tick();
        exc_vec = 16'h0001; mret_req = 1'b1; mip_in = 12'h800; mie_in = 12'h800;
        for (int k = 0; k < 5; k++) begin
            chk("drain_busy", 32'(u_if0.trap_busy), 32'd1);
            tick();
        end
        clear_events();
        pipe_clear = 1'b1;
        push_trap(32'h2, 32'h500, 32'hBEEF, 1'b1, 32'h8000, 32'h8000, cyc + 1);
        repeat (4) tick();
        chk("drain_done", 32'(cq.size() + pq0.size() + pq1.size()), 32'd0);

        // Held exception is accepted again three cycles after the first
        exc_vec = 16'h0800; epc_in = 32'hA00; tval_in = 32'h11;
        push_trap(32'hB, 32'hA00, 32'h11, 1'b1, 32'h8000, 32'h8000, cyc + 1);
        push_trap(32'hB, 32'hA00, 32'h11, 1'b1, 32'h8000, 32'h8000, cyc + 4);
        repeat (4) tick();
        clear_events();
        repeat (4) tick();
        chk("b2b_done", 32'(cq.size() + pq0.size() + pq1.size()), 32'd0);

        // Reset asserted while in COMMIT
        exc_vec = 16'h0004; epc_in = 32'h100; tval_in = 32'hDEAD;
        tick();
        clear_events();
        chk("pre_reset_commit", 32'(u_if0.mcause_rup), 32'd1);
        RST = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(|{u_if0.mcause_next, u_if0.mepc_next, u_if0.mtval_next,
            u_if0.mstatus_mie_next, u_if0.mstatus_mpie_next, u_if0.mcause_rup, u_if0.mepc_rup,
            u_if0.mtval_rup, u_if0.mstatus_rup, u_if0.insert_pc, u_if0.priv_pc, u_if0.trap_busy}), 32'd0);
        repeat (2) tick();
        RST = 1'b0;
        repeat (6) tick();
        chk("post_reset_idle", 32'(u_if0.trap_busy | u_if0.insert_pc), 32'd0);
        chk("post_reset_queues", 32'(cq.size() + pq0.size() + pq1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/priv_trap_sequencer.md
Name: priv_trap_sequencer

Overview:
- Machine-mode trap and return sequencer for the privilege block.
- Selects the highest-priority exception or enabled interrupt and waits for the pipeline to drain.
- Commits mcause/mepc/mtval/mstatus updates as one-cycle update strobes, then redirects fetch via insert_pc/priv_pc.
- Sequences mret the same way; sits between the pipeline hazard logic and the CSR file.

Parameters:
XLEN, 32, datapath width (only 32 supported)
VECTORED_EN, 1, 1 enables mtvec vectored mode for interrupts; 0 forces direct mode

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
exc_vec  input  16  exception request bits, bit i = exception cause code i
mip_in  input  12  pending interrupt bits (mip[11:0])
mie_in  input  12  interrupt enable bits (mie[11:0])
mstatus_mie  input  1  current mstatus.MIE
mstatus_mpie  input  1  current mstatus.MPIE
epc_in  input  32  pc of the faulting or interrupted instruction
tval_in  input  32  trap value accompanying exc_vec
mret_req  input  1  mret instruction reached commit
pipe_clear  input  1  pipeline drained, safe to redirect
mtvec_in  input  32  current mtvec
mepc_in  input  32  current mepc
mcause_next  output  32  value for mcause
mepc_next  output  32  value for mepc
mtval_next  output  32  value for mtval
mstatus_mie_next  output  1  value for mstatus.MIE
mstatus_mpie_next  output  1  value for mstatus.MPIE
mcause_rup, mepc_rup, mtval_rup, mstatus_rup  output  1 each  one-cycle write strobes to the CSR file
insert_pc  output  1  one-cycle fetch redirect strobe
priv_pc  output  32  redirect target, valid while insert_pc=1
trap_busy  output  1  high whenever state != IDLE; pipeline holds fetch

Behaviour:
- States: IDLE, WAIT_CLEAR, COMMIT, MRET_COMMIT, REDIRECT.
- Reset (asynchronous, any state): state=IDLE; all strobes 0; all *_next, priv_pc and latches 0; trap_busy=0.

Event detection, IDLE only:
- irq_en = mip_in & mie_in & {12{mstatus_mie}}.
- Exception priority, highest first: 12,1,2,0,11,9,8,3,6,4,15,13,7,5. Bits 10 and 14 are ignored.
- Interrupt priority, highest first: 11,3,7,9,1,5,8,0,4. Bits 2, 6 and 10 are ignored.
- Any exception beats any interrupt; trap beats mret_req when both are present in the same cycle (the mret is dropped).
- On a trap, latch:
  - cause = {is_int, 26'b0, code[4:0]}
  - epc = epc_in
  - tval = tval_in for exceptions, 0 for interrupts
  - is_int
- Next state = COMMIT if pipe_clear=1, else WAIT_CLEAR.
- On mret_req with no trap: next state = MRET_COMMIT if pipe_clear=1, else WAIT_CLEAR (mret flag latched).

WAIT_CLEAR:
- Latches frozen; new exc_vec, mip_in and mret_req are ignored.
- Leaves to COMMIT or MRET_COMMIT on the first cycle with pipe_clear=1.

COMMIT (exactly 1 cycle):
- Strobes: mcause_rup=mepc_rup=mtval_rup=mstatus_rup=1.
- mcause_next=latched cause; mepc_next={latched epc[31:2],2'b00}; mtval_next=latched tval.
- mstatus_mpie_next=mstatus_mie; mstatus_mie_next=0.
- Next state: REDIRECT.

MRET_COMMIT (exactly 1 cycle):
- Strobes: mstatus_rup=1 only.
- mstatus_mie_next=mstatus_mpie; mstatus_mpie_next=1.
- Next state: REDIRECT.

REDIRECT (exactly 1 cycle):
- insert_pc=1; next state IDLE.
- Trap target:
  - base = {mtvec_in[31:2],2'b00}.
  - If VECTORED_EN=1, mtvec_in[1:0]==2'b01 and is_int: priv_pc = base + (code << 2), 32-bit wrap.
  - Otherwise priv_pc = base. mtvec mode values 2 and 3 are treated as direct.
- Mret target: priv_pc = {mepc_in[31:2],2'b00}, sampled in REDIRECT.

Timing and output rules:
- Latency with pipe_clear already high: event in cycle N, COMMIT in N+1, REDIRECT in N+2, back in IDLE at N+3. Events are accepted again from N+3.
- Strobes and insert_pc are registered outputs, never asserted in IDLE or WAIT_CLEAR.
- *_next values hold their last value when not strobed.

Test Plan:
- Illegal instruction: exc_vec=0x0004, epc_in=0x100, tval_in=0xDEAD, pipe_clear=1 -> cycle+1: mcause_next=0x2, mepc_next=0x100, mtval_next=0xDEAD, all four strobes high; cycle+2: insert_pc=1, priv_pc=mtvec base 0x8000 (mtvec_in=0x8000).
- Vectored timer interrupt: mip_in=mie_in=0x080, mstatus_mie=1, mtvec_in=0x8001 -> mcause_next=0x80000007, mtval_next=0, mstatus_mie_next=0, mstatus_mpie_next=1, priv_pc=0x801C; repeat with VECTORED_EN=0 -> priv_pc=0x8000.
- Priority: exc_vec=0x0808 (ecall-M and breakpoint) plus pending enabled MEI plus mret_req -> mcause_next=0xB, one trap sequence only, no mret commit.
- Drain wait: exception with pipe_clear=0 for 5 cycles, exc_vec changed to 0x0001 meanwhile -> trap_busy high, no strobes; after pipe_clear rises, mcause_next=0x2 (original latch).
- Mret: mret_req=1, mstatus_mpie=1, mepc_in=0x1236, pipe_clear=1 -> only mstatus_rup pulses, mstatus_mie_next=1, mstatus_mpie_next=1; next cycle insert_pc=1, priv_pc=0x1234.
- RST asserted during COMMIT -> all outputs 0 asynchronously, state IDLE; after release with no events, no strobes and no insert_pc.
